def_cmd_sched: RTL

DEF_CMD_SCHED -- requirements
Module: def_cmd_sched

---
 rtl/def_cmd_pkg.sv | 22 ++
 rtl/def_cmd_fifo.sv | 61 ++++++
 rtl/def_cmd_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/def_cmd_pkg.sv
// Shared definitions for the two-channel command scheduler: address window
// offsets, control register bit positions and the per-channel FSM encoding.
package def_cmd_pkg;

  localparam int NUM_CH = 2;

  // Offsets from BASE_ADDR inside the 4-address command window
  localparam logic [7:0] OFF_CH0   = 8'd0;
  localparam logic [7:0] OFF_CH1   = 8'd1;
  localparam logic [7:0] OFF_BCAST = 8'd2;
  localparam logic [7:0] OFF_CTRL  = 8'd3;

  // Control register bits
  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

  // Per-channel presenter FSM
  localparam int STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE    = 1'b0;
  localparam logic [STATE_W-1:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/def_cmd_fifo.sv
// Single-clock synchronous FIFO, DEPTH x 32, with occupancy output and a
// synchronous flush. The caller never pushes when full nor pops when empty.
module def_cmd_fifo
  import def_cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [6:0]  level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [31:0]      mem_q [DEPTH];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = 7'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + 7'(push) - 7'(pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = cnt_q;

endmodule

// File: rtl/def_cmd_sched.sv
// Two-channel command scheduler: decodes NIOS bus writes into per-channel
// FIFOs and presents one registered word per channel to its transmitter.
// Optional feature macro: DEF_CMD_BCAST_EN enables the broadcast address.
module def_cmd_sched
  import def_cmd_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_wr,
  input  logic [7:0]       cmd_addr,
  input  logic [31:0]      cmd_data,
  output logic [1:0][31:0] cntr_data,
  output logic [1:0]       cntr_valid,
  input  logic [1:0]       cntrtr_ready,
  output logic [1:0][6:0]  fifo_level,
  output logic [1:0]       ovf
);

  localparam logic [7:0] ADDR_CH0  = BASE_ADDR + OFF_CH0;
  localparam logic [7:0] ADDR_CH1  = BASE_ADDR + OFF_CH1;
  localparam logic [7:0] ADDR_CTRL = BASE_ADDR + OFF_CTRL;

  logic [1:0]         wr_req, push, pop, full, empty, ovf_set;
  logic               bcast, ctrl_wr, flush, ovf_clr;
  logic [1:0][31:0]   head;
  logic [1:0][6:0]    level;
  logic [1:0][31:0]   data_q, data_d;
  logic [1:0]         ovf_q, ovf_d;
  logic [STATE_W-1:0] state_q [NUM_CH];
  logic [STATE_W-1:0] state_d [NUM_CH];

  // Address decode; broadcast hardware only exists when the feature is enabled
  always_comb begin
`ifdef DEF_CMD_BCAST_EN
    bcast = cmd_wr && (cmd_addr == (BASE_ADDR + OFF_BCAST));
`else
    bcast = 1'b0;
`endif
    ctrl_wr   = cmd_wr && (cmd_addr == ADDR_CTRL);
    flush     = ctrl_wr && cmd_data[CTRL_FLUSH_BIT];
    ovf_clr   = ctrl_wr && cmd_data[CTRL_OVF_CLR_BIT];
    wr_req[0] = (cmd_wr && (cmd_addr == ADDR_CH0)) || bcast;
    wr_req[1] = (cmd_wr && (cmd_addr == ADDR_CH1)) || bcast;
  end

  // Admission uses the level at the start of the cycle, so a same-cycle pop never makes room
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      full[n]    = (level[n] == 7'(DEPTH));
      empty[n]   = (level[n] == 7'd0);
      push[n]    = wr_req[n] && !full[n] && !flush;
      ovf_set[n] = wr_req[n] && full[n];
    end
    ovf_d = (ovf_q & ~{2{ovf_clr}}) | ovf_set;
  end

  // Presenter FSM per channel: load head on entry, reload back-to-back on handshake
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
      pop[n]     = 1'b0;
      case (state_q[n])
        ST_IDLE: begin
          if (!empty[n] && !flush) begin
            pop[n]     = 1'b1;
            data_d[n]  = head[n];
            state_d[n] = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (cntrtr_ready[n]) begin
            if (!empty[n] && !flush) begin
              pop[n]    = 1'b1;
              data_d[n] = head[n];
            end else begin
              state_d[n] = ST_IDLE;
            end
          end
        end
        default: state_d[n] = ST_IDLE;
      endcase
    end
  end

  // Presenter and overflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) state_q[n] <= ST_IDLE;
      data_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) state_q[n] <= state_d[n];
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    def_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (flush),
      .wdata (cmd_data),
      .rdata (head[g]),
      .level (level[g])
    );
    assign cntr_valid[g] = (state_q[g] == ST_PRESENT);
  end

  assign cntr_data  = data_q;
  assign fifo_level = level;
  assign ovf        = ovf_q;

endmodule
